// File: rtl/ngsx_rx_filter_pkg.sv
// Shared definitions for the NGSX receive filter: FSM state encoding,
// error counter width and a constant-friendly ceiling-log2 helper.
package ngsx_rx_filter_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        STALE = 2'd3
    } stateT;

    localparam int ERR_CNT_W = 8;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ngsx_bit_filter.sv
// Per-bit debounce: counts consecutive good frames whose bit differs from the
// committed image and flags a commit on the FILTER_FRAMES-th such frame.
module ngsx_bit_filter
    import ngsx_rx_filter_pkg::*;
#(
    parameter int FILTER_FRAMES = 3
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iGoodStrobe,
    input  logic iNewBit,
    input  logic iCurBit,
    input  logic iLoadClear,
    output logic oCommit
);

    localparam int CW = (clog2(FILTER_FRAMES) < 1) ? 1 : clog2(FILTER_FRAMES);
    localparam logic [CW-1:0] LAST = CW'(FILTER_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic          differ;

    assign differ  = iNewBit ^ iCurBit;
    assign oCommit = iGoodStrobe & differ & (cnt == LAST);

    // A matching frame or a commit restarts the run of differing frames.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt <= '0;
        end else if (iLoadClear) begin
            cnt <= '0;
        end else if (iGoodStrobe) begin
            if (!differ || oCommit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ngsx_rx_filter.sv
// SGPIO receive post-processing: frame-length check, multi-frame debounce of
// the recovered register image, change reporting and link-stale detection.
module ngsx_rx_filter
    import ngsx_rx_filter_pkg::*;
#(
    parameter int                     BYTE_REGS      = 1,
    parameter int                     FILTER_FRAMES  = 3,
    parameter int                     TIMEOUT_FRAMES = 4,
    parameter logic [BYTE_REGS*8-1:0] RESET_VAL      = '0
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iLoad_n,
    input  logic [BYTE_REGS*8-1:0]   iPData,
    input  logic                     iClrErr,
    output logic [BYTE_REGS*8-1:0]   oPData,
    output logic                     oValid,
    output logic                     oChange,
    output logic [BYTE_REGS*8-1:0]   oChangeMask,
    output logic                     oStale,
    output logic                     oFrameErr,
    output logic [ERR_CNT_W-1:0]     oErrCnt
);

    localparam int W    = BYTE_REGS * 8;
    localparam int TMAX = TIMEOUT_FRAMES * W;
    localparam int IW   = clog2(TMAX + 1);
    localparam int MW   = clog2(FILTER_FRAMES + 1);

    stateT          state;
    logic           rLoadQ;
    logic           strobe;
    logic           goodFrame;
    logic           frameErr;
    logic           goodRun;
    logic           loadClear;
    logic [IW-1:0]  intervalCnt;
    logic [W-1:0]   candidate;
    logic [MW-1:0]  matchCnt;
    logic [W-1:0]   commitVec;

    assign strobe    = iLoad_n & ~rLoadQ;
    assign goodFrame = strobe && (intervalCnt == IW'(W));
    assign frameErr  = strobe && !goodFrame && ((state == FILL) || (state == RUN));
    assign goodRun   = goodFrame && (state == RUN);
    assign loadClear = (state != RUN);

    // rLoadQ idles high so a released reset cannot fake a strobe.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rLoadQ      <= 1'b1;
            intervalCnt <= '0;
        end else begin
            rLoadQ <= iLoad_n;
            if (strobe) begin
                intervalCnt <= IW'(1);
            end else if (intervalCnt != IW'(TMAX)) begin
                intervalCnt <= intervalCnt + IW'(1);
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : gBit
        ngsx_bit_filter #(
            .FILTER_FRAMES (FILTER_FRAMES)
        ) uBit (
            .iClk        (iClk),
            .iRst_n      (iRst_n),
            .iGoodStrobe (goodRun),
            .iNewBit     (iPData[i]),
            .iCurBit     (oPData[i]),
            .iLoadClear  (loadClear),
            .oCommit     (commitVec[i])
        );
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= INIT;
            oPData      <= RESET_VAL;
            oValid      <= 1'b0;
            oChange     <= 1'b0;
            oChangeMask <= '0;
            oStale      <= 1'b0;
            oFrameErr   <= 1'b0;
            oErrCnt     <= '0;
            candidate   <= '0;
            matchCnt    <= '0;
        end else begin
            oChange   <= 1'b0;
            oFrameErr <= frameErr;

            if (iClrErr) begin
                oErrCnt <= '0;
            end else if (frameErr && (oErrCnt != '1)) begin
                oErrCnt <= oErrCnt + ERR_CNT_W'(1);
            end

            case (state)
                INIT: begin
                    if (strobe) begin
                        state    <= FILL;
                        matchCnt <= '0;
                    end
                end

                // Image is adopted only after FILTER_FRAMES identical good frames.
                FILL: begin
                    if (strobe) begin
                        if (goodFrame) begin
                            if ((matchCnt == '0) || (iPData != candidate)) begin
                                candidate <= iPData;
                                matchCnt  <= MW'(1);
                            end else if (matchCnt == MW'(FILTER_FRAMES - 1)) begin
                                oPData   <= candidate;
                                oValid   <= 1'b1;
                                matchCnt <= '0;
                                state    <= RUN;
                            end else begin
                                matchCnt <= matchCnt + MW'(1);
                            end
                        end
                    end else if (intervalCnt == IW'(TMAX)) begin
                        oStale <= 1'b1;
                        oValid <= 1'b0;
                        state  <= STALE;
                    end
                end

                RUN: begin
                    if (strobe) begin
                        if (goodFrame && (|commitVec)) begin
                            oPData      <= oPData ^ commitVec;
                            oChange     <= 1'b1;
                            oChangeMask <= commitVec;
                        end
                    end else if (intervalCnt == IW'(TMAX)) begin
                        oStale <= 1'b1;
                        oValid <= 1'b0;
                        state  <= STALE;
                    end
                end

                STALE: begin
                    if (strobe) begin
                        oStale   <= 1'b0;
                        matchCnt <= '0;
                        state    <= FILL;
                    end
                end

                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ngsx_rx_filter.sv
// Directed scoreboard bench for ngsx_rx_filter with one byte register,
// three-frame filtering and a four-frame stale timeout.
module tb_ngsx_rx_filter;

    logic       iClk;
    logic       iRst_n;
    logic       iLoad_n;
    logic [7:0] iPData;
    logic       iClrErr;
    logic [7:0] oPData;
    logic       oValid;
    logic       oChange;
    logic [7:0] oChangeMask;
    logic       oStale;
    logic       oFrameErr;
    logic [7:0] oErrCnt;

    typedef struct packed {
        logic [7:0] pData;
        logic       valid;
        logic       change;
        logic [7:0] mask;
        logic       stale;
        logic       frameErr;
        logic [7:0] errCnt;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;

    ngsx_rx_filter #(
        .BYTE_REGS      (1),
        .FILTER_FRAMES  (3),
        .TIMEOUT_FRAMES (4),
        .RESET_VAL      (8'h00)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iLoad_n     (iLoad_n),
        .iPData      (iPData),
        .iClrErr     (iClrErr),
        .oPData      (oPData),
        .oValid      (oValid),
        .oChange     (oChange),
        .oChangeMask (oChangeMask),
        .oStale      (oStale),
        .oFrameErr   (oFrameErr),
        .oErrCnt     (oErrCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic expT mkExp(input logic [7:0] pData, input logic valid,
                                  input logic change, input logic [7:0] mask,
                                  input logic stale, input logic frameErr,
                                  input logic [7:0] errCnt);
        expT e;
        e.pData    = pData;
        e.valid    = valid;
        e.change   = change;
        e.mask     = mask;
        e.stale    = stale;
        e.frameErr = frameErr;
        e.errCnt   = errCnt;
        return e;
    endfunction

    task automatic compareField(input string tag, input string field,
                                input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s: observed %h, expected %h", tag, field, obs, exp);
        end
    endtask

    // Pops the next expected image and compares every output against it.
    task automatic checkOutput(input string tag);
        expT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, observed pData %h, expected an entry", tag, oPData);
        end else begin
            e = expQ.pop_front();
            compareField(tag, "pData",    oPData,                e.pData);
            compareField(tag, "valid",    {7'b0, oValid},        {7'b0, e.valid});
            compareField(tag, "change",   {7'b0, oChange},       {7'b0, e.change});
            compareField(tag, "mask",     oChangeMask,           e.mask);
            compareField(tag, "stale",    {7'b0, oStale},        {7'b0, e.stale});
            compareField(tag, "frameErr", {7'b0, oFrameErr},     {7'b0, e.frameErr});
            compareField(tag, "errCnt",   oErrCnt,               e.errCnt);
        end
    endtask

    // Called just after a strobe edge; the next strobe lands len clocks later.
    task automatic applyStimulus(input logic [7:0] data, input int len, input logic clr,
                                 input expT e, input string tag);
        expQ.push_back(e);
        repeat (len - 1) @(negedge iClk);
        iLoad_n = 1'b0;
        iPData  = data;
        @(negedge iClk);
        iLoad_n = 1'b1;
        iClrErr = clr;
        @(posedge iClk);
        #1;
        iClrErr = 1'b0;
        checkOutput(tag);
    endtask

    initial begin
        iRst_n  = 1'b1;
        iLoad_n = 1'b1;
        iPData  = 8'h00;
        iClrErr = 1'b0;
        #2;
        iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        expQ.push_back(mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00));
        checkOutput("reset");
        @(negedge iClk);
        iRst_n = 1'b1;

        // Sync strobe then three identical good frames fill the image.
        applyStimulus(8'hA5, 8, 0, mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00), "sync");
        applyStimulus(8'hA5, 8, 0, mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00), "fill1");
        applyStimulus(8'hA5, 8, 0, mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00), "fill2");
        applyStimulus(8'hA5, 8, 0, mkExp(8'hA5, 1, 0, 8'h00, 0, 0, 8'h00), "fillDone");

        // Two-frame glitch on bit 1 is rejected.
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA5, 1, 0, 8'h00, 0, 0, 8'h00), "glitch1");
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA5, 1, 0, 8'h00, 0, 0, 8'h00), "glitch2");
        applyStimulus(8'hA5, 8, 0, mkExp(8'hA5, 1, 0, 8'h00, 0, 0, 8'h00), "glitchBack");

        // Three-frame change on bit 1 commits.
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA5, 1, 0, 8'h00, 0, 0, 8'h00), "hold1");
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA5, 1, 0, 8'h00, 0, 0, 8'h00), "hold2");
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA7, 1, 1, 8'h02, 0, 0, 8'h00), "commit");
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA7, 1, 0, 8'h02, 0, 0, 8'h00), "changeHold");

        // Short frame is an error and its data is discarded.
        applyStimulus(8'h00, 7, 0, mkExp(8'hA7, 1, 0, 8'h02, 0, 1, 8'h01), "shortFrame");
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA7, 1, 0, 8'h02, 0, 0, 8'h01), "afterShort");

        for (int k = 2; k <= 300; k++) begin
            applyStimulus(8'h00, 7, 0,
                          mkExp(8'hA7, 1, 0, 8'h02, 0, 1, (k > 255) ? 8'hFF : 8'(k)), "errSat");
        end

        applyStimulus(8'h00, 7, 1, mkExp(8'hA7, 1, 0, 8'h02, 0, 1, 8'h00), "clrWithErr");
        applyStimulus(8'hA7, 8, 0, mkExp(8'hA7, 1, 0, 8'h02, 0, 0, 8'h00), "afterClr");

        // Strobes stop: stale exactly 32 clocks after the last one.
        expQ.push_back(mkExp(8'hA7, 1, 0, 8'h02, 0, 0, 8'h00));
        repeat (31) @(posedge iClk);
        #1;
        checkOutput("preStale");
        expQ.push_back(mkExp(8'hA7, 0, 0, 8'h02, 1, 0, 8'h00));
        @(posedge iClk);
        #1;
        checkOutput("stale");

        // Resume: sync, then a reload before three matching frames.
        applyStimulus(8'h5A, 8, 0, mkExp(8'hA7, 0, 0, 8'h02, 0, 0, 8'h00), "resumeSync");
        applyStimulus(8'h11, 8, 0, mkExp(8'hA7, 0, 0, 8'h02, 0, 0, 8'h00), "resumeOdd");
        applyStimulus(8'h5A, 8, 0, mkExp(8'hA7, 0, 0, 8'h02, 0, 0, 8'h00), "resume1");
        applyStimulus(8'h5A, 8, 0, mkExp(8'hA7, 0, 0, 8'h02, 0, 0, 8'h00), "resume2");
        applyStimulus(8'h5A, 8, 0, mkExp(8'h5A, 1, 0, 8'h02, 0, 0, 8'h00), "resumeDone");
        applyStimulus(8'h00, 7, 0, mkExp(8'h5A, 1, 0, 8'h02, 0, 1, 8'h01), "resumeShort");
        applyStimulus(8'h5A, 8, 0, mkExp(8'h5A, 1, 0, 8'h02, 0, 0, 8'h01), "resumeGood");

        // Asynchronous reset between strobes.
        repeat (3) @(posedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        expQ.push_back(mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00));
        checkOutput("midReset");
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;

        applyStimulus(8'h3C, 8, 0, mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00), "postSync");
        applyStimulus(8'h3C, 8, 0, mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00), "post1");
        applyStimulus(8'h3C, 8, 0, mkExp(8'h00, 0, 0, 8'h00, 0, 0, 8'h00), "post2");
        applyStimulus(8'h3C, 8, 0, mkExp(8'h3C, 1, 0, 8'h00, 0, 0, 8'h00), "postDone");

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL leftover: observed %0d queued entries, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
